button_conditioner: RTL and testbench

//   Front-end for the menu push-buttons (up/left/right/confirm): synchronises raw

---
 rtl/button_if.sv | 31 +++
 rtl/button_conditioner.sv | 205 ++++++++++++++++++++
 tb/tb_button_conditioner.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/button_if.sv
// button_if
//   Bundles the raw button inputs and the conditioned outputs of
//   button_conditioner.
//   Modports:
//     slave  : the conditioner (takes btn_i, drives the conditioned outputs)
//     master : the surrounding logic (drives btn_i, consumes the outputs)
//   Signals:
//     btn_i        raw asynchronous button inputs, 1 = pressed
//     btn_level    debounced level
//     btn_press    one-cycle pulse on accepted press (and auto-repeats)
//     btn_release  one-cycle pulse on accepted release
//     any_held     OR of btn_level
interface button_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_i;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_held;

    modport master (
        output btn_i,
        input  btn_level, btn_press, btn_release, any_held
    );

    modport slave (
        input  btn_i,
        output btn_level, btn_press, btn_release, any_held
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronises, debounces and edge-detects the menu push-buttons. Each
//   button runs its own independent FSM; outputs are registered.
//   Ports:
//     clk   system clock, all state on the rising edge
//     rst   asynchronous active-high reset
//     bus   button_if.slave: btn_i in; btn_level, btn_press, btn_release,
//           any_held out
//   Optional feature: define AUTOREPEAT_EN to emit extra btn_press pulses
//   while a button stays held (REPEAT_DELAY after the press, then every
//   REPEAT_PERIOD). Without it, REPEAT_* only influence counter width.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   IDLE       | debounced level 0, waiting for raw input to rise
//   PRESS_WAIT | raw input high, counting stable cycles to accept press
//   HELD       | debounced level 1 (auto-repeat counting if enabled)
//   REL_WAIT   | raw input low, counting stable cycles to accept release
module button_conditioner #(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 2_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic     clk,
    input  logic     rst,
    button_if.slave  bus
);
    localparam int MAX_AB = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DB_C = CW'(DB_CYCLES);
`ifdef AUTOREPEAT_EN
    localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PER_C = CW'(REPEAT_PERIOD);
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] release_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_i;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] cnt_inc;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          in;

        assign in = sync2[i];
        // cnt counts stable cycles including the one that detected the change,
        // so the level flips DB_CYCLES edges after sync2 first shows the new
        // value. The FSM leaves the wait state when cnt reaches DB_CYCLES, so
        // the counter never passes that value and cannot wrap.
        assign cnt_inc = cnt_q + 1'b1;

`ifdef AUTOREPEAT_EN
        logic [CW-1:0] rcnt_q, rcnt_d;
        logic [CW-1:0] rcnt_inc;
        logic          rphase_q, rphase_d;   // 0: waiting first delay, 1: periodic
        assign rcnt_inc = rcnt_q + 1'b1;
`endif

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef AUTOREPEAT_EN
            rcnt_d    = rcnt_q;
            rphase_d  = rphase_q;
`endif
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (in) begin
                        if (cnt_inc == DB_C) begin
                            state_d = HELD;
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            state_d = PRESS_WAIT;
                            cnt_d   = cnt_inc;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!in) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == DB_C) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    cnt_d = '0;
                    if (!in) begin
                        if (cnt_inc == DB_C) begin
                            state_d   = IDLE;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            state_d = REL_WAIT;
                            cnt_d   = cnt_inc;
                        end
                    end
                end
                REL_WAIT: begin
                    if (in) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == DB_C) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase

`ifdef AUTOREPEAT_EN
            // Only cycles spent in HELD and staying there advance the repeat
            // count; REL_WAIT freezes it, returning to IDLE clears it.
            if (state_d == IDLE) begin
                rcnt_d   = '0;
                rphase_d = 1'b0;
            end else if (state_q == HELD && state_d == HELD) begin
                rcnt_d = rcnt_inc;
                if (rcnt_inc == (rphase_q ? PER_C : DLY_C)) begin
                    press_d  = 1'b1;
                    rcnt_d   = '0;
                    rphase_d = 1'b1;
                end
            end
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef AUTOREPEAT_EN
                rcnt_q    <= '0;
                rphase_q  <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef AUTOREPEAT_EN
                rcnt_q    <= rcnt_d;
                rphase_q  <= rphase_d;
`endif
            end
        end

        assign level_v[i]   = level_q;
        assign press_v[i]   = press_q;
        assign release_v[i] = release_q;
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.any_held    = |level_v;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Self-checking bench for button_conditioner with DB_CYCLES=8,
//   REPEAT_DELAY=20, REPEAT_PERIOD=5. A per-cycle vector table covers
//   glitch rejection, bounce, release, simultaneous press and auto-repeat;
//   a hand-written sequence covers asynchronous reset while held.
module tb_button_conditioner;
    localparam int N   = 4;
    localparam int DB  = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;

    typedef struct packed {
        logic [N-1:0] btn;
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    vec_t vecs[$];

    button_if #(.N_BTN(N)) bif ();

    button_conditioner #(
        .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    function automatic void push(logic [N-1:0] b, logic [N-1:0] l,
                                 logic [N-1:0] p, logic [N-1:0] r);
        vec_t v;
        v.btn = b; v.lvl = l; v.prs = p; v.rel = r;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [N-1:0] pick(bit c, logic [N-1:0] v);
        return c ? v : '0;
    endfunction

    initial begin
        int first_press;
        bit saw_release;
        bit rep;

`ifdef AUTOREPEAT_EN
        rep = 1'b1;
`else
        rep = 1'b0;
`endif

        // Glitch: btn[1] high 5 cycles then low; nothing may come out.
        for (int c = 0; c < 5; c++)  push(4'b0010, '0, '0, '0);
        for (int c = 0; c < 12; c++) push(4'b0000, '0, '0, '0);
        // Bounce on btn[0]: toggles every 3 cycles for 30, then held.
        // Last rise first sampled at c=30, accepted 9 edges later at c=39.
        for (int c = 0; c < 45; c++)
            push((c < 30) ? (((c / 3) % 2 == 0) ? 4'b0001 : 4'b0000) : 4'b0001,
                 pick(c >= 39, 4'b0001), pick(c == 39, 4'b0001), '0);
        // Release btn[0]: release pulse and level drop at c=9.
        for (int c = 0; c < 14; c++)
            push(4'b0000, pick(c < 9, 4'b0001), '0, pick(c == 9, 4'b0001));
        // Simultaneous press of buttons 0 and 3, then simultaneous release.
        for (int c = 0; c < 14; c++)
            push(4'b1001, pick(c >= 9, 4'b1001), pick(c == 9, 4'b1001), '0);
        for (int c = 0; c < 12; c++)
            push(4'b0000, pick(c < 9, 4'b1001), '0, pick(c == 9, 4'b1001));
        // Auto-repeat on btn[2]: press at c=9, repeats at +20,+25,+30,+35,+40.
        for (int c = 0; c < 50; c++)
            push(4'b0100, pick(c >= 9, 4'b0100),
                 pick(c == 9 || (rep && (c == 29 || c == 34 || c == 39 ||
                                         c == 44 || c == 49)), 4'b0100), '0);
        for (int c = 0; c < 12; c++)
            push(4'b0000, pick(c < 9, 4'b0100), '0, pick(c == 9, 4'b0100));

        bif.btn_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bif.btn_level, bif.btn_press, bif.btn_release, 3'b0, bif.any_held},
              32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            bif.btn_i = vecs[k].btn;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k),
                  {bif.btn_level, bif.btn_press, bif.btn_release, 3'b0, bif.any_held},
                  {vecs[k].lvl, vecs[k].prs, vecs[k].rel, 3'b0, |vecs[k].lvl});
        end

        // Reset while btn[3] held, then fresh press after debounce.
        @(negedge clk);
        bif.btn_i = 4'b1000;
        repeat (12) @(posedge clk);
        #1;
        check("hold_before_rst", {28'b0, bif.btn_level}, 32'h8);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_clear",
              {bif.btn_level, bif.btn_press, bif.btn_release, 3'b0, bif.any_held},
              32'h0);
        @(posedge clk);
        #1;
        check("rst_no_release", {28'b0, bif.btn_release}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        first_press = -1;
        saw_release = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bif.btn_release != '0) saw_release = 1'b1;
            if (first_press < 0 && bif.btn_press[3]) first_press = n;
        end
        check("post_rst_press_edge", first_press, 9);
        check("post_rst_no_release", {31'b0, saw_release}, 32'h0);
        check("post_rst_level", {27'b0, bif.btn_level, bif.any_held}, 32'h11);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
